// File: rtl/alu_pkg.sv
// Shared opcode map and FSM state encoding for the sequential execute ALU.
// Consumed by alu_seq and alu_seq_muldiv.
package alu_pkg;

  localparam logic [4:0] ADD    = 5'd0;
  localparam logic [4:0] SUB    = 5'd1;
  localparam logic [4:0] AND    = 5'd2;
  localparam logic [4:0] OR     = 5'd3;
  localparam logic [4:0] XOR    = 5'd4;
  localparam logic [4:0] SLL    = 5'd5;
  localparam logic [4:0] SRL    = 5'd6;
  localparam logic [4:0] SRA    = 5'd7;
  localparam logic [4:0] BEQ    = 5'd8;
  localparam logic [4:0] BNE    = 5'd9;
  localparam logic [4:0] BLT    = 5'd10;
  localparam logic [4:0] BGE    = 5'd11;
  localparam logic [4:0] BLTU   = 5'd12;
  localparam logic [4:0] BGEU   = 5'd13;
  localparam logic [4:0] MUL    = 5'd16;
  localparam logic [4:0] MULH   = 5'd17;
  localparam logic [4:0] MULHSU = 5'd18;
  localparam logic [4:0] MULHU  = 5'd19;
  localparam logic [4:0] DIV    = 5'd20;
  localparam logic [4:0] DIVU   = 5'd21;
  localparam logic [4:0] REM    = 5'd22;
  localparam logic [4:0] REMU   = 5'd23;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic is_mul(input logic [4:0] op);
    return (op == MUL) || (op == MULH) || (op == MULHSU) || (op == MULHU);
  endfunction

  function automatic logic is_div(input logic [4:0] op);
    return (op == DIV) || (op == DIVU) || (op == REM) || (op == REMU);
  endfunction

endpackage

// File: rtl/alu_seq_muldiv.sv
// Iterative RV32M engine: shift-add multiply and restoring divide, one bit per cycle.
// The divider datapath exists only when ALU_SEQ_DIV_EN is defined.
module alu_seq_muldiv
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             step_i,
  input  logic [4:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o
);

  localparam int CW = $clog2(WIDTH);

  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic             neg_q, neg_d;
  logic             hi_q, hi_d;
  logic             a_neg, b_neg;

  logic [WIDTH:0]     sum;
  logic [WIDTH-1:0]   acc_n, lo_n;
  logic [2*WIDTH-1:0] prod, prod_f;

`ifdef ALU_SEQ_DIV_EN
  logic             div_q, div_d;
  logic             rem_q, rem_d;
  logic             rneg_q, rneg_d;
  logic             dz_q, dz_d;
  logic [WIDTH:0]   shifted, diff;
  logic [WIDTH-1:0] quot, remd;
`endif

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  // One iteration: multiply keeps {acc,lo} as the running 2W product, divide keeps {rem,quot}
  always_comb begin
    sum   = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opb_q} : '0);
    acc_n = sum[WIDTH:1];
    lo_n  = {sum[0], lo_q[WIDTH-1:1]};
`ifdef ALU_SEQ_DIV_EN
    shifted = {acc_q, lo_q[WIDTH-1]};
    diff    = shifted - {1'b0, opb_q};
    if (div_q) begin
      if (!diff[WIDTH]) begin
        acc_n = diff[WIDTH-1:0];
        lo_n  = {lo_q[WIDTH-2:0], 1'b1};
      end else begin
        acc_n = shifted[WIDTH-1:0];
        lo_n  = {lo_q[WIDTH-2:0], 1'b0};
      end
    end
`endif
  end

  always_comb begin
    cnt_d = cnt_q;
    acc_d = acc_q;
    lo_d  = lo_q;
    opb_d = opb_q;
    neg_d = neg_q;
    hi_d  = hi_q;
    a_neg = 1'b0;
    b_neg = 1'b0;
`ifdef ALU_SEQ_DIV_EN
    div_d  = div_q;
    rem_d  = rem_q;
    rneg_d = rneg_q;
    dz_d   = dz_q;
`endif
    if (start_i) begin
      a_neg = ((op_i == MULH) || (op_i == MULHSU)) && a_i[WIDTH-1];
      b_neg = (op_i == MULH) && b_i[WIDTH-1];
`ifdef ALU_SEQ_DIV_EN
      if (is_div(op_i)) begin
        a_neg = ((op_i == DIV) || (op_i == REM)) && a_i[WIDTH-1];
        b_neg = ((op_i == DIV) || (op_i == REM)) && b_i[WIDTH-1];
      end
      div_d  = is_div(op_i);
      rem_d  = (op_i == REM) || (op_i == REMU);
      rneg_d = a_neg;
      dz_d   = (b_i == '0);
`endif
      // Multiply is commutative, so both engines take |a| in lo and |b| as the addend/divisor
      cnt_d = '0;
      acc_d = '0;
      lo_d  = mag(a_i, a_neg);
      opb_d = mag(b_i, b_neg);
      neg_d = a_neg ^ b_neg;
      hi_d  = (op_i != MUL);
    end else if (step_i) begin
      cnt_d = cnt_q + CW'(1);
      acc_d = acc_n;
      lo_d  = lo_n;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    acc_q <= acc_d;
    lo_q  <= lo_d;
    opb_q <= opb_d;
    neg_q <= neg_d;
    hi_q  <= hi_d;
`ifdef ALU_SEQ_DIV_EN
    div_q  <= div_d;
    rem_q  <= rem_d;
    rneg_q <= rneg_d;
    dz_q   <= dz_d;
`endif
  end

  assign done_o = step_i && (cnt_q == CW'(WIDTH - 1));

  // Result is formed from the final iteration's next-state so the top can register it on done
  always_comb begin
    prod     = {acc_n, lo_n};
    prod_f   = neg_q ? -prod : prod;
    result_o = hi_q ? prod_f[2*WIDTH-1:WIDTH] : prod_f[WIDTH-1:0];
`ifdef ALU_SEQ_DIV_EN
    quot = dz_q ? '1 : (neg_q ? -lo_n : lo_n);
    remd = rneg_q ? -acc_n : acc_n;
    if (div_q) begin
      result_o = rem_q ? remd : quot;
    end
`endif
  end

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle execute ALU with valid/ready on both sides; basic ops in one cycle, RV32M iterative.
// Optional feature macro: ALU_SEQ_DIV_EN (iterative divider; otherwise div/rem return all-ones).
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       alu_op,
  input  logic [WIDTH-1:0] rD1,
  input  logic [WIDTH-1:0] alu_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_c,
  output logic             alu_branch,
  output logic             busy
);

  localparam int SHW = $clog2(WIDTH);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] alu_c_q, alu_c_d;
  logic             br_q, br_d;
  logic             accept, iter_op, eng_done;
  logic [WIDTH-1:0] eng_res;
  logic [WIDTH:0]   basic_res;

  // Returns {branch_taken, result}; branch is 0 for anything that is not a branch
  function automatic logic [WIDTH:0] basic_op(input logic [4:0] op, input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] c;
    logic             br;
    logic [SHW-1:0]   sh;
    c  = '0;
    br = 1'b0;
    sh = b[SHW-1:0];
    case (op)
      ADD:  c = a + b;
      SUB:  c = a - b;
      AND:  c = a & b;
      OR:   c = a | b;
      XOR:  c = a ^ b;
      SLL:  c = a << sh;
      SRL:  c = a >> sh;
      SRA:  c = $signed(a) >>> sh;
      BEQ:  begin c = a - b; br = (a == b); end
      BNE:  begin c = a - b; br = (a != b); end
      BLT:  begin c = a - b; br = ($signed(a) < $signed(b)); end
      BGE:  begin c = a - b; br = ($signed(a) >= $signed(b)); end
      BLTU: begin c = a - b; br = (a < b); end
      BGEU: begin c = a - b; br = (a >= b); end
`ifndef ALU_SEQ_DIV_EN
      DIV, DIVU, REM, REMU: c = '1;
`endif
      default: c = '0;
    endcase
    return {br, c};
  endfunction

`ifdef ALU_SEQ_DIV_EN
  assign iter_op = is_mul(alu_op) || is_div(alu_op);
`else
  assign iter_op = is_mul(alu_op);
`endif

  assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign basic_res = basic_op(alu_op, rD1, alu_b);

  alu_seq_muldiv #(
    .WIDTH(WIDTH)
  ) u_muldiv (
    .clk     (clk),
    .rst     (rst),
    .start_i (accept && iter_op),
    .step_i  (state_q == CALC),
    .op_i    (alu_op),
    .a_i     (rD1),
    .b_i     (alu_b),
    .done_o  (eng_done),
    .result_o(eng_res)
  );

  always_comb begin
    state_d = state_q;
    alu_c_d = alu_c_q;
    br_d    = br_q;
    case (state_q)
      IDLE: ;
      CALC: begin
        if (eng_done) begin
          state_d = DONE;
          alu_c_d = eng_res;
          br_d    = 1'b0;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Accept is only possible in IDLE or on the DONE hand-off, so it overrides both
    if (accept) begin
      if (iter_op) begin
        state_d = CALC;
      end else begin
        state_d = DONE;
        alu_c_d = basic_res[WIDTH-1:0];
        br_d    = basic_res[WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      alu_c_q <= '0;
      br_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      alu_c_q <= alu_c_d;
      br_q    <= br_d;
    end
  end

  assign out_valid  = (state_q == DONE);
  assign busy       = (state_q == CALC);
  assign alu_c      = alu_c_q;
  assign alu_branch = br_q;

endmodule

// File: tb/tb_alu_seq.sv
// Randomised self-checking bench for alu_seq (WIDTH=32) against an arithmetic reference model.
// Honours ALU_SEQ_DIV_EN the same way the design does.
module tb_alu_seq;

`ifdef ALU_SEQ_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [4:0]  alu_op;
  logic [31:0] rD1, alu_b;
  logic        out_valid, out_ready;
  logic [31:0] alu_c;
  logic        alu_branch, busy;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_op    (alu_op),
    .rD1       (rD1),
    .alu_b     (alu_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .alu_c     (alu_c),
    .alu_branch(alu_branch),
    .busy      (busy)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: result and branch flag straight from the RV32 arithmetic definitions
  function automatic logic [32:0] ref_alu(input logic [4:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    longint      sa, sb, ua, ub, p;
    logic [31:0] c;
    logic        br;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    c  = 32'd0;
    br = 1'b0;
    case (op)
      5'd0:  c = a + b;
      5'd1:  c = a - b;
      5'd2:  c = a & b;
      5'd3:  c = a | b;
      5'd4:  c = a ^ b;
      5'd5:  c = a << b[4:0];
      5'd6:  c = a >> b[4:0];
      5'd7:  begin p = sa >>> b[4:0]; c = p[31:0]; end
      5'd8:  begin c = a - b; br = (ua == ub); end
      5'd9:  begin c = a - b; br = (ua != ub); end
      5'd10: begin c = a - b; br = (sa < sb); end
      5'd11: begin c = a - b; br = (sa >= sb); end
      5'd12: begin c = a - b; br = (ua < ub); end
      5'd13: begin c = a - b; br = (ua >= ub); end
      5'd16: begin p = sa * sb; c = p[31:0]; end
      5'd17: begin p = sa * sb; c = p[63:32]; end
      5'd18: begin p = sa * ub; c = p[63:32]; end
      5'd19: begin p = ua * ub; c = p[63:32]; end
      5'd20, 5'd21, 5'd22, 5'd23: begin
        if (!DIV_EN) c = '1;
        else if (b == 32'd0) c = (op == 5'd20 || op == 5'd21) ? 32'hFFFF_FFFF : a;
        else begin
          case (op)
            5'd20:   p = sa / sb;
            5'd21:   p = ua / ub;
            5'd22:   p = sa % sb;
            default: p = ua % ub;
          endcase
          c = p[31:0];
        end
      end
      default: c = 32'd0;
    endcase
    return {br, c};
  endfunction

  function automatic int ref_lat(input logic [4:0] op);
    if (op >= 5'd16 && op <= 5'd19) return 33;
    if (op >= 5'd20 && op <= 5'd23) return DIV_EN ? 33 : 1;
    return 1;
  endfunction

  function automatic logic [31:0] rnd_opnd();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  // Issue one op with out_ready high, then measure latency (edges from accept, inclusive)
  task automatic run_op(input string tag, input logic [4:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] ec, input logic eb,
                        input int elat);
    int lat, bz;
    @(negedge clk);
    alu_op = op; rD1 = a; alu_b = b; in_valid = 1'b1; out_ready = 1'b1;
    #1 check_eq({tag, ".in_ready"}, 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; alu_op = 5'($urandom); rD1 = $urandom; alu_b = $urandom;
    lat = 1; bz = 0;
    while (!out_valid && lat < 100) begin
      bz += int'(busy);
      @(posedge clk); #1;
      lat++;
    end
    check_eq({tag, ".lat"}, 64'(lat), 64'(elat));
    check_eq({tag, ".busy_cycles"}, 64'(bz), 64'(elat - 1));
    check_eq({tag, ".alu_c"}, 64'(alu_c), 64'(ec));
    check_eq({tag, ".branch"}, 64'(alu_branch), 64'(eb));
  endtask

  task automatic run_model(input string tag, input logic [4:0] op, input logic [31:0] a,
                           input logic [31:0] b);
    logic [32:0] r;
    r = ref_alu(op, a, b);
    run_op(tag, op, a, b, r[31:0], r[32], ref_lat(op));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] ops [24];
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    alu_op = 5'd0; rD1 = 32'd0; alu_b = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst.in_ready", 64'(in_ready), 64'd1);
    check_eq("rst.out_valid", 64'(out_valid), 64'd0);
    check_eq("rst.busy", 64'(busy), 64'd0);
    check_eq("rst.alu_c", 64'(alu_c), 64'd0);
    check_eq("rst.branch", 64'(alu_branch), 64'd0);
    @(negedge clk) rst = 1'b0;

    run_op("add_ovf", 5'd0, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 1'b0, 1);
    run_op("mul", 5'd16, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, 33);
    run_op("mulh", 5'd17, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 33);
    run_op("divu0", 5'd21, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b0, DIV_EN ? 33 : 1);
    run_op("remu0", 5'd23, 32'd5, 32'd0, DIV_EN ? 32'd5 : 32'hFFFF_FFFF, 1'b0, DIV_EN ? 33 : 1);
    run_op("div_ovf", 5'd20, 32'h8000_0000, 32'hFFFF_FFFF,
           DIV_EN ? 32'h8000_0000 : 32'hFFFF_FFFF, 1'b0, DIV_EN ? 33 : 1);
    run_op("rem_ovf", 5'd22, 32'h8000_0000, 32'hFFFF_FFFF,
           DIV_EN ? 32'd0 : 32'hFFFF_FFFF, 1'b0, DIV_EN ? 33 : 1);
    run_op("bltu", 5'd12, 32'd1, 32'hFFFF_FFFF, 32'd2, 1'b1, 1);
    run_op("blt", 5'd10, 32'd1, 32'hFFFF_FFFF, 32'd2, 1'b0, 1);
    run_op("add_after_br", 5'd0, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 1);
    run_op("sra", 5'd7, 32'h8000_0000, 32'd4, 32'hF800_0000, 1'b0, 1);
    run_op("sll_wrap", 5'd5, 32'h0000_0003, 32'h0000_0021, 32'h0000_0006, 1'b0, 1);
    run_op("undef", 5'd15, 32'h1234_5678, 32'd9, 32'd0, 1'b0, 1);

    // Output stall: result held, in_ready low, in_valid ignored; then same-cycle hand-off
    @(posedge clk);
    @(negedge clk);
    alu_op = 5'd0; rD1 = 32'h1234; alu_b = 32'h1111; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    alu_op = 5'd1; rD1 = 32'hDEAD; alu_b = 32'h1;
    check_eq("stall.valid0", 64'(out_valid), 64'd1);
    check_eq("stall.c0", 64'(alu_c), 64'h2345);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check_eq("stall.c_hold", 64'(alu_c), 64'h2345);
      check_eq("stall.in_ready", 64'(in_ready), 64'd0);
      check_eq("stall.valid_hold", 64'(out_valid), 64'd1);
    end
    @(negedge clk);
    out_ready = 1'b1; alu_op = 5'd4; rD1 = 32'hF0F0; alu_b = 32'h0FF0;
    #1 check_eq("b2b.in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check_eq("b2b.valid", 64'(out_valid), 64'd1);
    check_eq("b2b.c", 64'(alu_c), 64'hFF00);

    // Reset during a multiply discards it
    @(posedge clk);
    @(negedge clk);
    alu_op = 5'd16; rD1 = 32'd123; alu_b = 32'd456; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    check_eq("rstmid.out_valid", 64'(out_valid), 64'd0);
    check_eq("rstmid.busy", 64'(busy), 64'd0);
    check_eq("rstmid.in_ready", 64'(in_ready), 64'd1);
    check_eq("rstmid.alu_c", 64'(alu_c), 64'd0);
    @(negedge clk) rst = 1'b0;
    run_op("add_after_rst", 5'd0, 32'd2, 32'd3, 32'd5, 1'b0, 1);

    for (int i = 0; i < 24; i++) ops[i] = (i < 14) ? 5'(i) : 5'(i + 2);
    ops[22] = 5'd14;
    ops[23] = 5'd27;
    for (int i = 0; i < 70; i++) begin
      run_model("rnd", ops[$urandom_range(0, 23)], rnd_opnd(), rnd_opnd());
    end

    @(posedge clk); #1;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
